// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared Brainfuck opcode bytes and loop-scanner state encoding
//
// Purpose: opcode byte constants for the eight BF instructions, the scanner
//          FSM state type, and helpers that pick the bracket bytes for a
//          given scan direction.
// Ports:   none (package).

package bf_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;  // '+'
    localparam logic [7:0] OP_DEC   = 8'h2D;  // '-'
    localparam logic [7:0] OP_LEFT  = 8'h3C;  // '<'
    localparam logic [7:0] OP_RIGHT = 8'h3E;  // '>'
    localparam logic [7:0] OP_OUT   = 8'h2E;  // '.'
    localparam logic [7:0] OP_IN    = 8'h2C;  // ','
    localparam logic [7:0] OP_OPEN  = 8'h5B;  // '['
    localparam logic [7:0] OP_CLOSE = 8'h5D;  // ']'

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } scan_state_t;

    // Bracket of the same kind as the scan origin: it opens a nested level.
    function automatic logic [7:0] same_bracket(input logic backward);
        return backward ? OP_CLOSE : OP_OPEN;
    endfunction

    // Opposite bracket: it closes a nested level or ends the scan.
    function automatic logic [7:0] other_bracket(input logic backward);
        return backward ? OP_OPEN : OP_CLOSE;
    endfunction

endpackage

// File: rtl/bf_loop_scanner.sv
// rtl/bf_loop_scanner.sv - bracket-matching scanner for a BF program memory
//
// Purpose: starting next to a '[' (forward) or ']' (backward), walks program
//          memory one byte per two cycles, tracking nesting depth, and
//          reports the address of the matching bracket or an error.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a scan (accepted only while idle)
//   dir             0 = forward from '[', 1 = backward from ']'
//   start_pc        address of the originating bracket
//   prog_addr       program-memory read address (held while idle)
//   prog_data       read data, valid one cycle after prog_addr
//   busy            scan in progress
//   done            one-cycle pulse, match found
//   match_pc        address of the matching bracket (held)
//   error           one-cycle pulse, unmatched bracket or depth overflow

module bf_loop_scanner #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] start_pc,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] match_pc,
    output logic              error
);

    import bf_pkg::*;

    localparam logic [ADDR_W-1:0]  PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]  PC_MAX    = {ADDR_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

    scan_state_t        state;
    logic [ADDR_W-1:0]  pc;
    logic [DEPTH_W-1:0] depth;
    logic               scan_dir;

    logic [ADDR_W-1:0]  first_pc;
    logic               start_at_edge;
    logic [ADDR_W-1:0]  next_pc;
    logic               pc_at_edge;
    logic               is_same;
    logic               is_other;

    always_comb begin
        first_pc      = dir ? (start_pc - PC_ONE) : (start_pc + PC_ONE);
        // Stepping off the origin would wrap the address: refuse up front.
        start_at_edge = dir ? (start_pc == '0) : (start_pc == PC_MAX);
        next_pc       = scan_dir ? (pc - PC_ONE) : (pc + PC_ONE);
        pc_at_edge    = scan_dir ? (pc == '0) : (pc == PC_MAX);
        is_same       = (prog_data == same_bracket(scan_dir));
        is_other      = (prog_data == other_bracket(scan_dir));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= '0;
            depth     <= '0;
            scan_dir  <= 1'b0;
            prog_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            match_pc  <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (start_at_edge) begin
                            error <= 1'b1;
                        end else begin
                            pc        <= first_pc;
                            prog_addr <= first_pc;
                            depth     <= '0;
                            scan_dir  <= dir;
                            busy      <= 1'b1;
                            state     <= ST_ADDR;
                        end
                    end
                end

                // prog_addr already carries pc; this cycle is the memory read.
                ST_ADDR: begin
                    state <= ST_DATA;
                end

                ST_DATA: begin
                    if (is_same && depth == DEPTH_MAX) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (is_other && depth == '0) begin
                        match_pc <= pc;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        if (is_same) begin
                            depth <= depth + DEPTH_ONE;
                        end else if (is_other) begin
                            depth <= depth - DEPTH_ONE;
                        end
                        // Last address in the scan direction holds no match.
                        if (pc_at_edge) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            pc        <= next_pc;
                            prog_addr <= next_pc;
                            state     <= ST_ADDR;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_loop_scanner.sv
// tb/tb_bf_loop_scanner.sv - self-checking bench for bf_loop_scanner

module tb_bf_loop_scanner;

    localparam int AW = 8;
    localparam int DW = 3;
    localparam int K_NONE = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    localparam int BUDGET = 1200;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dir;
    logic [AW-1:0] start_pc;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] match_pc;
    logic          error;

    bf_loop_scanner #(.ADDR_W(AW), .DEPTH_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .start_pc  (start_pc),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .busy      (busy),
        .done      (done),
        .match_pc  (match_pc),
        .error     (error)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    always @(posedge clk) prog_data <= mem[prog_addr];

    int checks = 0;
    int errors = 0;
    int last_match = 0;

    typedef struct {
        int prog;
        int sp;
        int d;
        int kind;
        int mpc;
        int lat;
        int inject;
    } vec_t;

    vec_t  vecs [9];
    string progs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_prog(input string s);
        for (int a = 0; a < 256; a++) mem[a] = 8'h2E;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    endtask

    // Reference: walk memory with an integer depth counter.
    function automatic void model(input int sp, input int d, output int kind,
                                  output int mpc, output int lat);
        int pc, depth, n, maxd;
        logic [7:0] same, other;
        maxd = (1 << DW) - 1;
        kind = K_ERR;
        mpc  = 0;
        lat  = 1;
        if ((d == 0 && sp == 255) || (d == 1 && sp == 0)) return;
        same  = (d == 1) ? 8'h5D : 8'h5B;
        other = (d == 1) ? 8'h5B : 8'h5D;
        pc    = (d == 1) ? sp - 1 : sp + 1;
        depth = 0;
        n     = 0;
        while (1) begin
            n++;
            if (mem[pc] == same) begin
                if (depth == maxd) break;
                depth++;
            end else if (mem[pc] == other) begin
                if (depth == 0) begin
                    kind = K_DONE;
                    mpc  = pc;
                    break;
                end
                depth--;
            end
            if ((d == 0 && pc == 255) || (d == 1 && pc == 0)) break;
            pc = (d == 1) ? pc - 1 : pc + 1;
        end
        lat = 2 * n + 1;
    endfunction

    task automatic run_scan(input string name, input int sp, input int d,
                            input int exp_kind, input int exp_mpc, input int exp_lat,
                            input int inject, input bit release_rst);
        int cyc;
        int busy_bad;
        int got;
        busy_bad = 0;
        @(negedge clk);
        if (release_rst) rst = 1'b0;
        start    = 1'b1;
        dir      = d[0];
        start_pc = sp[AW-1:0];
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!(done || error) && cyc < BUDGET) begin
            if (!busy) busy_bad++;
            if (cyc == inject) begin
                start    = 1'b1;
                dir      = ~d[0];
                start_pc = 8'h80;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        got = done ? K_DONE : (error ? K_ERR : K_NONE);
        check({name, " excl"}, int'(done && error), 0);
        check({name, " kind"}, got, exp_kind);
        check({name, " latency"}, cyc, exp_lat);
        check({name, " busy_during"}, busy_bad, 0);
        check({name, " busy_end"}, int'(busy), 0);
        if (exp_kind == K_DONE) last_match = exp_mpc;
        check({name, " match_pc"}, int'(match_pc), last_match);
        @(negedge clk);
        check({name, " pulse_width"}, int'(done || error), 0);
    endtask

    initial begin
        int kind, mpc, lat, r;
        int sp, d;

        progs[0] = "[+]";
        progs[1] = "[[-]>]";
        progs[2] = "[++";
        progs[3] = "[[[[[[[[[[";
        progs[4] = "+-]";
        progs[5] = "[[]]";

        //          prog sp   d  kind    mpc lat  inject
        vecs[0] = '{0,   0,   0, K_DONE, 2,  5,   -1};
        vecs[1] = '{1,   0,   0, K_DONE, 5,  11,  3};
        vecs[2] = '{1,   5,   1, K_DONE, 0,  11,  -1};
        vecs[3] = '{0,   255, 0, K_ERR,  0,  1,   -1};
        vecs[4] = '{0,   0,   1, K_ERR,  0,  1,   -1};
        vecs[5] = '{2,   0,   0, K_ERR,  0,  511, -1};
        vecs[6] = '{3,   0,   0, K_ERR,  0,  17,  -1};
        vecs[7] = '{4,   2,   1, K_ERR,  0,  5,   -1};
        vecs[8] = '{5,   3,   1, K_DONE, 0,  7,   -1};

        rst      = 1'b1;
        start    = 1'b0;
        dir      = 1'b0;
        start_pc = '0;
        load_prog("");
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset error", int'(error), 0);
        check("reset match_pc", int'(match_pc), 0);
        check("reset prog_addr", int'(prog_addr), 0);

        // First scan starts in the very cycle reset is released.
        load_prog(progs[0]);
        run_scan("first", 0, 0, K_DONE, 2, 5, -1, 1'b1);

        for (int i = 0; i < 9; i++) begin
            load_prog(progs[vecs[i].prog]);
            run_scan($sformatf("vec%0d", i), vecs[i].sp, vecs[i].d, vecs[i].kind,
                     vecs[i].mpc, vecs[i].lat, vecs[i].inject, 1'b0);
            if (i == 5) check("vec5 no_wrap prog_addr", int'(prog_addr), 255);
        end

        // Reset in the third cycle of a scan.
        load_prog(progs[1]);
        run_scan("pre_rst", 0, 0, K_DONE, 5, 11, -1, 1'b0);
        @(negedge clk);
        start    = 1'b1;
        dir      = 1'b0;
        start_pc = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", int'(busy), 0);
        check("midrst match_pc", int'(match_pc), 0);
        check("midrst pulses", int'(done || error), 0);
        last_match = 0;
        load_prog(progs[0]);
        run_scan("after_rst", 0, 0, K_DONE, 2, 5, -1, 1'b1);

        // Randomised programs against the reference walk.
        for (int t = 0; t < 30; t++) begin
            for (int a = 0; a < 256; a++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1:    mem[a] = 8'h5B;
                    2, 3:    mem[a] = 8'h5D;
                    4:       mem[a] = 8'h2B;
                    5:       mem[a] = 8'h2D;
                    6:       mem[a] = 8'h3C;
                    7:       mem[a] = 8'h3E;
                    8:       mem[a] = 8'h2C;
                    default: mem[a] = 8'h2E;
                endcase
            end
            sp = $urandom_range(0, 255);
            d  = $urandom_range(0, 1);
            if (t % 10 == 9) sp = (d == 1) ? 0 : 255;
            model(sp, d, kind, mpc, lat);
            run_scan($sformatf("rand%0d", t), sp, d, kind, mpc, lat,
                     (lat > 9) ? 2 : -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bf_loop_scanner.md
BF_LOOP_SCANNER -- requirements
Module: bf_loop_scanner

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width.
REQ-002 Parameter DEPTH_W, default 8, nesting-depth counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a scan; sampled only in IDLE.
REQ-006 dir  input  1  0 = forward scan from '[', 1 = backward scan from ']'; sampled with start.
REQ-007 start_pc  input  ADDR_W  address of the bracket that triggered the scan; sampled with start.
REQ-008 prog_addr  output  ADDR_W  program-memory read address.
REQ-009 prog_data  input  8  program-memory read data, valid one cycle after prog_addr is presented.
REQ-010 busy  output  1  high from the cycle after start is accepted until done or error pulses.
REQ-011 done  output  1  one-cycle pulse when the matching bracket is found.
REQ-012 match_pc  output  ADDR_W  address of the matching bracket; held until the next accepted start.
REQ-013 error  output  1  one-cycle pulse on an unmatched bracket or depth overflow.

Function
REQ-014 States: IDLE, ADDR, DATA.
REQ-015 IDLE + start: pc <= start_pc stepped one position (start_pc+1 forward, start_pc-1 backward); depth <= 0; next state ADDR.
REQ-016 IDLE + start with start_pc at the boundary (all-ones forward, zero backward): error pulses next cycle; FSM stays in IDLE.
REQ-017 ADDR: prog_addr = pc; next state DATA.
REQ-018 DATA: prog_data is for pc; classify it as same = the bracket type of the scan origin ('[' 8'h5B forward, ']' 8'h5D backward), or other = the opposite bracket.
REQ-019 DATA, same: depth <= depth+1.
REQ-020 DATA, same, depth already all-ones: error pulse; go to IDLE.
REQ-021 DATA, other, depth == 0: match_pc <= pc; done pulse; go to IDLE.
REQ-022 DATA, other, depth != 0: depth <= depth-1.
REQ-023 DATA, any non-bracket byte: depth unchanged.
REQ-024 Pointer step: whenever DATA does not terminate, pc steps one position in scan direction and the state returns to ADDR.
REQ-025 DATA, no match, pc at the boundary (all-ones forward, zero backward): error pulse; go to IDLE; pc never wraps.
REQ-026 Throughput: exactly 2 cycles per scanned byte; done or error is asserted in the cycle after the terminating DATA state.
REQ-027 start is ignored while busy is high.
REQ-028 done and error are never high in the same cycle.
REQ-029 prog_addr holds its last value in IDLE.

Reset
REQ-030 rst, applied in any state including mid-scan, forces next state IDLE.
REQ-031 On reset: busy=0, done=0, error=0, match_pc=0, prog_addr=0, depth=0.
REQ-032 The first start is accepted in the cycle after rst deasserts.

Structure
REQ-033 Shared package bf_pkg holds the opcode byte constants (8'h5B '[', 8'h5D ']', plus the other six BF opcodes) and the state encoding.
REQ-034 No sub-module; a single FSM plus pc, depth and match_pc registers.

Verification
REQ-035 Memory "[+]" at 0..2, start_pc=0, dir=0 -> done after 2 bytes scanned (4 cycles), match_pc=2.
REQ-036 Memory "[[-]>]" at 0..5, start_pc=0, dir=0 -> depth peaks at 1, match_pc=5; same memory with start_pc=5, dir=1 -> match_pc=0.
REQ-037 Memory "[++" followed by no ']' up to address 255 -> error pulse with pc=255; done stays 0; no wrap to 0.
REQ-038 start_pc=255, dir=0 -> error pulse one cycle later; busy never rises.
REQ-039 rst asserted in the third cycle of a scan -> next cycle busy=0 and match_pc=0; a fresh start then completes normally.
REQ-040 start pulsed while busy -> ignored; the original scan's match_pc is unaffected.
